// File: rtl/lr35902_ppu_timing.sv
// LCD dot/line timing generator and PPU register file (FF40-FF4B) for the LR35902 system.
// Produces lx/ly/mode, line/frame strobes and edge-detected VBLANK/STAT interrupt pulses.
module lr35902_ppu_timing #(
    parameter int H_TOTAL  = 456,
    parameter int V_TOTAL  = 154,
    parameter int V_ACTIVE = 144,
    parameter int OAM_END  = 80,
    parameter int XFER_END = 252,
    parameter int LX_W     = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      reg_adr,
    input  logic [7:0]      reg_din,
    input  logic            reg_write,
    input  logic            reg_read,
    output logic [7:0]      reg_dout,
    output logic            irq_vblank,
    output logic            irq_stat,
    output logic [LX_W-1:0] lx,
    output logic [7:0]      ly,
    output logic [1:0]      mode,
    output logic            line_start,
    output logic            frame_start
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_t;

    localparam logic [LX_W-1:0] LX_LAST = LX_W'(H_TOTAL - 1);
    localparam logic [LX_W-1:0] LX_OAM  = LX_W'(OAM_END);
    localparam logic [LX_W-1:0] LX_XFER = LX_W'(XFER_END);
    localparam logic [7:0]      LY_LAST = 8'(V_TOTAL - 1);
    localparam logic [7:0]      LY_VBL  = 8'(V_ACTIVE);

    logic [7:0] lcdc, scy, scx, lyc, bgp, obp0, obp1, wy, wx;
    logic [3:0] stat_en;   // STAT[6:3]: coincidence, mode2, mode1, mode0 enables
    logic       coinc;
    logic       stat_line;
    mode_t      mode_q;

    logic            wr_lcdc, wr_ly, lcd_on_nxt;
    logic [LX_W-1:0] lx_nxt;
    logic [7:0]      ly_nxt;
    mode_t           mode_nxt;
    logic            coinc_nxt, line_nxt;
    logic [7:0]      rd_data;

    assign wr_lcdc    = reg_write && (reg_adr == 4'h0);
    assign wr_ly      = reg_write && (reg_adr == 4'h4);
    assign lcd_on_nxt = wr_lcdc ? reg_din[7] : lcdc[7];
    assign mode       = mode_q;

    // Counters sit at 0 while off and for the first cycle after switching on; an LY write overrides a wrap.
    always_comb begin
        lx_nxt = '0;
        ly_nxt = '0;
        if (lcd_on_nxt && lcdc[7] && !wr_ly) begin
            if (lx == LX_LAST) begin
                lx_nxt = '0;
                ly_nxt = (ly == LY_LAST) ? 8'd0 : ly + 8'd1;
            end else begin
                lx_nxt = lx + LX_W'(1);
                ly_nxt = ly;
            end
        end
    end

    always_comb begin
        mode_nxt = MODE_HBLANK;
        if (lcd_on_nxt) begin
            if (ly_nxt >= LY_VBL)       mode_nxt = MODE_VBLANK;
            else if (lx_nxt < LX_OAM)   mode_nxt = MODE_OAM;
            else if (lx_nxt < LX_XFER)  mode_nxt = MODE_XFER;
            else                        mode_nxt = MODE_HBLANK;
        end
    end

    // Everything below is computed from next-state so the registered flags line up with lx/ly.
    assign coinc_nxt = (ly_nxt == lyc);
    assign line_nxt  = lcd_on_nxt &
                       ((coinc_nxt & stat_en[3]) |
                        ((mode_nxt == MODE_OAM)    & stat_en[2]) |
                        ((mode_nxt == MODE_VBLANK) & stat_en[1]) |
                        ((mode_nxt == MODE_HBLANK) & stat_en[0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lx          <= '0;
            ly          <= '0;
            mode_q      <= MODE_HBLANK;
            coinc       <= 1'b0;
            stat_line   <= 1'b0;
            irq_stat    <= 1'b0;
            irq_vblank  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            lx          <= lx_nxt;
            ly          <= ly_nxt;
            mode_q      <= mode_nxt;
            coinc       <= coinc_nxt;
            stat_line   <= line_nxt;
            irq_stat    <= line_nxt & ~stat_line;
            irq_vblank  <= (mode_nxt == MODE_VBLANK) && (mode_q != MODE_VBLANK);
            line_start  <= lcd_on_nxt && (lx_nxt == '0);
            frame_start <= lcd_on_nxt && (lx_nxt == '0) && (ly_nxt == 8'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcdc    <= '0;
            stat_en <= '0;
            scy     <= '0;
            scx     <= '0;
            lyc     <= '0;
            bgp     <= '0;
            obp0    <= '0;
            obp1    <= '0;
            wy      <= '0;
            wx      <= '0;
        end else if (reg_write) begin
            case (reg_adr)
                4'h0:    lcdc    <= reg_din;
                4'h1:    stat_en <= reg_din[6:3];
                4'h2:    scy     <= reg_din;
                4'h3:    scx     <= reg_din;
                4'h5:    lyc     <= reg_din;
                4'h7:    bgp     <= reg_din;
                4'h8:    obp0    <= reg_din;
                4'h9:    obp1    <= reg_din;
                4'hA:    wy      <= reg_din;
                4'hB:    wx      <= reg_din;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'hFF;
        case (reg_adr)
            4'h0:    rd_data = lcdc;
            4'h1:    rd_data = {1'b1, stat_en, coinc, mode_q};
            4'h2:    rd_data = scy;
            4'h3:    rd_data = scx;
            4'h4:    rd_data = ly;
            4'h5:    rd_data = lyc;
            4'h7:    rd_data = bgp;
            4'h8:    rd_data = obp0;
            4'h9:    rd_data = obp1;
            4'hA:    rd_data = wy;
            4'hB:    rd_data = wx;
            default: rd_data = 8'hFF;
        endcase
    end

    // Read data samples pre-write register state, so a same-cycle write is not visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         reg_dout <= '0;
        else if (reg_read) reg_dout <= rd_data;
    end

endmodule
